// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package data_mem_responder_pkg;

    // Responder FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    // Wait-cycle counter width; covers LATENCY 0..15.
    localparam int unsigned LAT_W = 4;

    // Byte-lane geometry of a 32-bit word.
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = BYTE_LANES * BYTE_W;

    // Response defaults: no data, no error.
    localparam logic [WORD_W-1:0] RSP_RDATA_NONE = '0;
    localparam logic              RSP_ERROR_NONE = 1'b0;

    // A byte address is word-aligned when its two low bits are clear.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/word_store_bank.sv
// Word-organised storage with byte-enable synchronous write and asynchronous read.
module word_store_bank
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned WORD_BITS = 14
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [WORD_BITS-1:0]  addr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [BYTE_LANES-1:0] byte_en,
    output logic [WORD_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << WORD_BITS;

    logic [WORD_W-1:0] mem [DEPTH];

    // Commit only the enabled byte lanes; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (byte_en[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder: one outstanding access, fixed wait latency.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wEn,
    input  logic [ADDRESS_BITS-1:0] req_addr,
    input  logic [WORD_W-1:0]       req_wdata,
    input  logic [BYTE_LANES-1:0]   req_byte_en,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_W-1:0]       rsp_rdata,
    output logic                    rsp_error
);

    localparam int unsigned WORD_BITS = ADDRESS_BITS - 2;

    state_t                  state_q;
    logic [LAT_W-1:0]        cnt_q;
    logic                    wen_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [WORD_W-1:0]       wdata_q;
    logic [BYTE_LANES-1:0]   byte_en_q;
    logic [WORD_W-1:0]       rdata_q;
    logic                    error_q;

    logic                    access;
    logic                    aligned;
    logic                    mem_we;
    logic [WORD_W-1:0]       mem_rdata;

    // The access happens on the edge that leaves BUSY with the counter drained.
    always_comb begin
        access  = (state_q == BUSY) && (cnt_q == '0);
        aligned = is_word_aligned(addr_q[1:0]);
        mem_we  = access && wen_q && aligned;
    end

    // Request fields are captured only on the acceptance edge.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && req_valid) begin
            wen_q     <= req_wEn;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            byte_en_q <= req_byte_en;
        end
    end

    // FSM, latency counter and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= RSP_RDATA_NONE;
            error_q <= RSP_ERROR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= BUSY;
                        cnt_q   <= LAT_W'(LATENCY);
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end else begin
                        state_q <= RESP;
                        if (!aligned) begin
                            error_q <= 1'b1;
                            rdata_q <= RSP_RDATA_NONE;
                        end else if (wen_q) begin
                            rdata_q <= RSP_RDATA_NONE;
                        end else begin
                            rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                        rdata_q <= RSP_RDATA_NONE;
                        error_q <= RSP_ERROR_NONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are decoded straight from the state.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_error = error_q;
    end

    word_store_bank #(
        .WORD_BITS (WORD_BITS)
    ) u_bank (
        .clock   (clock),
        .we      (mem_we),
        .addr    (addr_q[ADDRESS_BITS-1:2]),
        .wdata   (wdata_q),
        .byte_en (byte_en_q),
        .rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 main instance, LATENCY=0 throughput instance.
module tb_data_mem_responder;

    logic        clock;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_wEn;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byte_en;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    logic        req_valid0;
    logic        req_ready0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;
    logic        rsp_error0;

    int checks;
    int errors;

    data_mem_responder #(
        .ADDRESS_BITS (16),
        .LATENCY      (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wEn     (req_wEn),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error)
    );

    data_mem_responder #(
        .ADDRESS_BITS (16),
        .LATENCY      (0)
    ) dut0 (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid0),
        .req_ready   (req_ready0),
        .req_wEn     (1'b1),
        .req_addr    (16'h0004),
        .req_wdata   (32'h5A5A5A5A),
        .req_byte_en (4'hF),
        .rsp_valid   (rsp_valid0),
        .rsp_ready   (1'b1),
        .rsp_rdata   (rsp_rdata0),
        .rsp_error   (rsp_error0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance with timing and data checks.
    task automatic do_req(input string tag, input vec_t v);
        int n;
        @(negedge clock);
        check({tag, " req_ready before accept"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_wEn     = v.wen;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_byte_en = v.be;
        @(posedge clock);
        #1;
        // Scramble request fields: the responder must have latched them already.
        req_valid   = 1'b0;
        req_wEn     = ~v.wen;
        req_addr    = 16'hFFFC;
        req_wdata   = 32'h0BAD0BAD;
        req_byte_en = 4'hF;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, " latency edges"}, 32'(n), 32'd3);
        check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, " rsp_error"}, 32'(rsp_error), 32'(v.exp_err));
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
        check({tag, " req_ready after handshake"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat_r [12];
        bit pat_v [12];
        bit pat_ok;
        int n;
        vec_t v;

        checks = 0;
        errors = 0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_wEn = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_byte_en = '0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0;

        //            wen   addr      wdata          be     exp_rdata      err
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'b1111, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h00000000, 4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0020, 32'h11223344, 4'b1111, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0020, 32'h00000000, 4'b0000, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b0, 16'h0022, 32'h00000000, 4'b0000, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 16'h0020, 32'h00000000, 4'b0000, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b1, 16'h0040, 32'h01020304, 4'b1111, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 16'h0040, 32'h55555555, 4'b0000, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 16'h0040, 32'h00000000, 4'b0000, 32'h01020304, 1'b0};
        vecs[10] = '{1'b1, 16'h0041, 32'hFFFFFFFF, 4'b1111, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 16'h0040, 32'h00000000, 4'b1111, 32'h01020304, 1'b0};
        vecs[12] = '{1'b1, 16'h0040, 32'hA5000000, 4'b1000, 32'h00000000, 1'b0};
        vecs[13] = '{1'b0, 16'h0040, 32'h00000000, 4'b0000, 32'hA5020304, 1'b0};

        // Reset state.
        #2 reset = 1'b1;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_error", 32'(rsp_error), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: response held for 10 cycles while a new request is offered.
        @(negedge clock);
        req_valid = 1'b1;
        req_wEn = 1'b0;
        req_addr = 16'h0010;
        @(posedge clock);
        #1;
        req_wEn = 1'b1;
        req_wdata = 32'h99999999;
        req_byte_en = 4'hF;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("bp latency edges", 32'(n), 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("bp rsp_valid c%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp rsp_rdata c%0d", i), rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp req_ready c%0d", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check("bp req_ready after release", 32'(req_ready), 32'd1);
        v = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        do_req("bp reload", v);

        // Reset while BUSY drops the pending store.
        v = '{1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        do_req("rst preload", v);
        @(negedge clock);
        req_valid = 1'b1;
        req_wEn = 1'b1;
        req_addr = 16'h0030;
        req_wdata = 32'h12345678;
        req_byte_en = 4'hF;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check("rst busy req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst async req_ready", 32'(req_ready), 32'd1);
        check("rst async rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst async rsp_rdata", rsp_rdata, 32'd0);
        check("rst async rsp_error", 32'(rsp_error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        v = '{1'b0, 16'h0030, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        do_req("rst reload", v);

        // LATENCY=0 back-to-back with rsp_ready tied high: period of 3 cycles.
        @(negedge clock);
        req_valid0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            pat_r[i] = req_ready0;
            pat_v[i] = rsp_valid0;
            if (rsp_valid0) begin
                check($sformatf("lat0 rsp_rdata c%0d", i), rsp_rdata0, 32'd0);
                check($sformatf("lat0 rsp_error c%0d", i), 32'(rsp_error0), 32'd0);
            end
        end
        req_valid0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("lat0 req_ready c%0d", i), 32'(pat_r[i]), 32'((i % 3) == 0));
            check($sformatf("lat0 rsp_valid c%0d", i), 32'(pat_v[i]), 32'((i % 3) == 2));
        end
        pat_ok = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
